// File: rtl/pcie_lite_pkg.sv
// pcie_lite_pkg: LTSSM, TLP, error and completion encodings plus timing constants for pcie_lite.
// Latency: none (definitions only); backpressure: n/a.
package pcie_lite_pkg;

  typedef enum logic [3:0] {
    LT_DETECT   = 4'd0,
    LT_POLLING  = 4'd1,
    LT_CONFIG   = 4'd2,
    LT_L0       = 4'd3,
    LT_RECOVERY = 4'd4
  } ltssm_e;

  localparam logic [2:0] TLP_MRD = 3'd0;
  localparam logic [2:0] TLP_MWR = 3'd1;

  localparam logic [3:0] ERR_LCRC        = 4'd1;
  localparam logic [3:0] ERR_CPL_TIMEOUT = 4'd2;
  localparam logic [3:0] ERR_ECRC        = 4'd3;
  localparam logic [3:0] ERR_MALFORMED   = 4'd4;

  localparam logic [2:0] CPL_SC = 3'b000;
  localparam logic [2:0] CPL_CA = 3'b100;

  localparam int LINK_TRAIN_CYC  = 10;
  localparam int RECOVERY_CYC    = 20;
  localparam int CPL_LAT_CYC     = 4;
  localparam int CPL_TIMEOUT_CYC = 64;

  localparam logic [2:0] LINK_SPEED_L0 = 3'd3;
  localparam logic [4:0] LINK_WIDTH_L0 = 5'd16;

  typedef struct packed {
    logic [4:0]  rsvd0;
    logic [2:0]  typ;
    logic [7:0]  tag;
    logic [5:0]  rsvd1;
    logic [9:0]  length;
    logic [31:0] address;
  } hdr_t;

  function automatic hdr_t make_hdr(input logic [2:0] typ, input logic [7:0] tag,
                                    input logic [9:0] length, input logic [31:0] address);
    hdr_t h;
    h         = '0;
    h.typ     = typ;
    h.tag     = tag;
    h.length  = length;
    h.address = address;
    return h;
  endfunction

endpackage

// File: rtl/pcie_lite_ltssm.sv
// pcie_lite_ltssm: link training state machine with LCRC rising-edge detect and link status outputs.
// Latency: state steps after 10/10/10 cycles of training, 20 cycles of recovery; backpressure: none.
module pcie_lite_ltssm
  import pcie_lite_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       crc_err,
  output ltssm_e     state,
  output logic       lcrc_evt,
  output logic       link_up,
  output logic [2:0] link_speed,
  output logic [4:0] link_width
);

  ltssm_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       crc_q;
  logic       crc_rise;

  assign crc_rise = crc_err & ~crc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LT_DETECT;
      cnt_q   <= '0;
      crc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_err;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 5'd1;
    lcrc_evt = 1'b0;
    unique case (state_q)
      LT_DETECT: begin
        if (cnt_q == 5'(LINK_TRAIN_CYC - 1)) begin
          state_d = LT_POLLING;
          cnt_d   = '0;
        end
      end
      LT_POLLING: begin
        if (cnt_q == 5'(LINK_TRAIN_CYC - 1)) begin
          state_d = LT_CONFIG;
          cnt_d   = '0;
        end
      end
      LT_CONFIG: begin
        if (cnt_q == 5'(LINK_TRAIN_CYC - 1)) begin
          state_d = LT_L0;
          cnt_d   = '0;
        end
      end
      LT_L0: begin
        cnt_d = '0;
        if (crc_rise) begin
          state_d  = LT_RECOVERY;
          lcrc_evt = 1'b1;
        end
      end
      LT_RECOVERY: begin
        if (cnt_q == 5'(RECOVERY_CYC - 1)) begin
          state_d = LT_L0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = LT_DETECT;
        cnt_d   = '0;
      end
    endcase
  end

  assign state      = state_q;
  assign link_up    = (state_q == LT_L0);
  assign link_speed = link_up ? LINK_SPEED_L0 : 3'd0;
  assign link_width = link_up ? LINK_WIDTH_L0 : 5'd0;

endmodule

// File: rtl/pcie_lite.sv
// pcie_lite: single-outstanding MRd/MWr endpoint over a 16x32 memory with error reporting; PCIE_LITE_ERR_INJ_EN enables inject_* inputs.
// Latency: completion 4 cycles after MRd acceptance; backpressure: tlp_ready low off-L0 or with a read outstanding, completion held until cpl_ready.
module pcie_lite
  import pcie_lite_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tlp_valid,
  input  logic [2:0]  tlp_type,
  input  logic [31:0] tlp_address,
  input  logic [31:0] tlp_data,
  input  logic [7:0]  tlp_tag,
  input  logic [9:0]  tlp_length,
  output logic        tlp_ready,
  output logic        cpl_valid,
  output logic [2:0]  cpl_status,
  output logic [31:0] cpl_data,
  output logic [7:0]  cpl_tag,
  input  logic        cpl_ready,
  input  logic        inject_crc_error,
  input  logic        inject_timeout,
  input  logic        inject_ecrc_error,
  input  logic        inject_malformed_tlp,
  output logic        error_valid,
  output logic [3:0]  error_type,
  output logic [63:0] error_header,
  output logic [3:0]  ltssm_state,
  output logic        link_up,
  output logic [2:0]  link_speed,
  output logic [4:0]  link_width
);

  localparam int NSRC = 4;
  // Source index doubles as report priority: 0 is served first.
  localparam logic [3:0] SRC_CODE [NSRC] = '{ERR_LCRC, ERR_MALFORMED, ERR_ECRC, ERR_CPL_TIMEOUT};

  logic inj_crc, inj_to, inj_ecrc, inj_mal;
`ifdef PCIE_LITE_ERR_INJ_EN
  assign inj_crc  = inject_crc_error;
  assign inj_to   = inject_timeout;
  assign inj_ecrc = inject_ecrc_error;
  assign inj_mal  = inject_malformed_tlp;
`else
  logic unused_inj;
  assign unused_inj = ^{inject_crc_error, inject_timeout, inject_ecrc_error, inject_malformed_tlp};
  assign inj_crc    = 1'b0;
  assign inj_to     = 1'b0;
  assign inj_ecrc   = 1'b0;
  assign inj_mal    = 1'b0;
`endif

  ltssm_e lt_state;
  logic   lcrc_evt;

  pcie_lite_ltssm u_ltssm (
    .clk        (clk),
    .rst_n      (rst_n),
    .crc_err    (inj_crc),
    .state      (lt_state),
    .lcrc_evt   (lcrc_evt),
    .link_up    (link_up),
    .link_speed (link_speed),
    .link_width (link_width)
  );

  assign ltssm_state = lt_state;

  logic [31:0] mem [16];
  logic        rd_out_q, rd_cpl_q, rd_ca_q, rd_to_q;
  logic [6:0]  rd_cnt_q;
  logic [7:0]  rd_tag_q;
  logic [3:0]  rd_idx_q;
  hdr_t        rd_hdr_q, last_hdr_q, acc_hdr;
  logic        acc, mal, acc_mal, acc_ecrc, acc_wr, acc_rd;
  logic        cpl_fire, to_fire, cpl_hs;

  logic [NSRC-1:0] evt, pend_q, gnt;
  hdr_t            evt_hdr    [NSRC];
  hdr_t            pend_hdr_q [NSRC];

  assign tlp_ready = link_up && !rd_out_q;
  assign acc       = tlp_valid && tlp_ready;
  assign acc_hdr   = make_hdr(tlp_type, tlp_tag, tlp_length, tlp_address);
  assign mal       = ((tlp_type != TLP_MRD) && (tlp_type != TLP_MWR)) || (tlp_length != 10'd1) || inj_mal;
  assign acc_mal   = acc && mal;
  assign acc_ecrc  = acc && !mal && inj_ecrc;
  assign acc_wr    = acc && !mal && (tlp_type == TLP_MWR) && !inj_ecrc;
  assign acc_rd    = acc && !mal && (tlp_type == TLP_MRD);
  assign cpl_hs    = cpl_valid && cpl_ready;

  // Completions only leave while the link is in L0; a read finishing during recovery waits here.
  assign cpl_fire = rd_out_q && !rd_to_q && !rd_cpl_q && link_up && (rd_cnt_q >= 7'(CPL_LAT_CYC - 1));
  assign to_fire  = rd_out_q && rd_to_q && (rd_cnt_q == 7'(CPL_TIMEOUT_CYC - 2));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      last_hdr_q <= '0;
    end else if (acc) begin
      last_hdr_q <= acc_hdr;
      if (acc_wr) mem[tlp_address[5:2]] <= tlp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_out_q <= 1'b0;
      rd_cpl_q <= 1'b0;
      rd_ca_q  <= 1'b0;
      rd_to_q  <= 1'b0;
      rd_cnt_q <= '0;
      rd_tag_q <= '0;
      rd_idx_q <= '0;
      rd_hdr_q <= '0;
    end else if (acc_rd) begin
      rd_out_q <= 1'b1;
      rd_cpl_q <= 1'b0;
      rd_ca_q  <= inj_ecrc;
      rd_to_q  <= inj_to;
      rd_cnt_q <= '0;
      rd_tag_q <= tlp_tag;
      rd_idx_q <= tlp_address[5:2];
      rd_hdr_q <= acc_hdr;
    end else if (rd_out_q) begin
      if (rd_cnt_q != 7'(CPL_TIMEOUT_CYC - 1)) rd_cnt_q <= rd_cnt_q + 7'd1;
      if (cpl_fire) rd_cpl_q <= 1'b1;
      if (cpl_hs || gnt[3]) rd_out_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpl_valid  <= 1'b0;
      cpl_status <= '0;
      cpl_data   <= '0;
      cpl_tag    <= '0;
    end else begin
      if (cpl_hs) cpl_valid <= 1'b0;
      if (cpl_fire) begin
        cpl_valid  <= 1'b1;
        cpl_tag    <= rd_tag_q;
        cpl_status <= rd_ca_q ? CPL_CA : CPL_SC;
        cpl_data   <= rd_ca_q ? 32'd0 : mem[rd_idx_q];
      end
    end
  end

  assign evt        = {to_fire, acc_ecrc, acc_mal, lcrc_evt};
  assign evt_hdr[0] = last_hdr_q;
  assign evt_hdr[1] = acc_hdr;
  assign evt_hdr[2] = acc_hdr;
  assign evt_hdr[3] = rd_hdr_q;

  always_comb begin
    gnt = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q       <= '0;
      error_valid  <= 1'b0;
      error_type   <= '0;
      error_header <= '0;
      for (int i = 0; i < NSRC; i++) pend_hdr_q[i] <= '0;
    end else begin
      error_valid <= |gnt;
      for (int i = 0; i < NSRC; i++) begin
        if (gnt[i]) begin
          error_type   <= SRC_CODE[i];
          error_header <= pend_hdr_q[i];
        end
        pend_q[i] <= (pend_q[i] & ~gnt[i]) | evt[i];
        if (evt[i] && (!pend_q[i] || gnt[i])) pend_hdr_q[i] <= evt_hdr[i];
      end
    end
  end

endmodule

// File: tb/tb_pcie_lite.sv
// tb_pcie_lite: randomized transaction bench for pcie_lite against a transaction-level reference model.
`timescale 1ns/1ps
module tb_pcie_lite;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tlp_valid;
  logic [2:0]  tlp_type;
  logic [31:0] tlp_address;
  logic [31:0] tlp_data;
  logic [7:0]  tlp_tag;
  logic [9:0]  tlp_length;
  logic        tlp_ready;
  logic        cpl_valid;
  logic [2:0]  cpl_status;
  logic [31:0] cpl_data;
  logic [7:0]  cpl_tag;
  logic        cpl_ready;
  logic        inject_crc_error, inject_timeout, inject_ecrc_error, inject_malformed_tlp;
  logic        error_valid;
  logic [3:0]  error_type;
  logic [63:0] error_header;
  logic [3:0]  ltssm_state;
  logic        link_up;
  logic [2:0]  link_speed;
  logic [4:0]  link_width;

  always #5 clk = ~clk;

  pcie_lite dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .tlp_valid            (tlp_valid),
    .tlp_type             (tlp_type),
    .tlp_address          (tlp_address),
    .tlp_data             (tlp_data),
    .tlp_tag              (tlp_tag),
    .tlp_length           (tlp_length),
    .tlp_ready            (tlp_ready),
    .cpl_valid            (cpl_valid),
    .cpl_status           (cpl_status),
    .cpl_data             (cpl_data),
    .cpl_tag              (cpl_tag),
    .cpl_ready            (cpl_ready),
    .inject_crc_error     (inject_crc_error),
    .inject_timeout       (inject_timeout),
    .inject_ecrc_error    (inject_ecrc_error),
    .inject_malformed_tlp (inject_malformed_tlp),
    .error_valid          (error_valid),
    .error_type           (error_type),
    .error_header         (error_header),
    .ltssm_state          (ltssm_state),
    .link_up              (link_up),
    .link_speed           (link_speed),
    .link_width           (link_width)
  );

`ifdef PCIE_LITE_ERR_INJ_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  int          checks = 0;
  int          failures = 0;
  logic [31:0] ref_mem [16];
  logic [63:0] ref_last_hdr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!tlp_ready && n < 200) begin
      tick();
      n++;
    end
    check("ready_wait", tlp_ready, 1);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    ref_last_hdr = '0;
  endtask

  task automatic reset_and_train();
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_ltssm", ltssm_state, 0);
    check("rst_ready_cpl_err", {tlp_ready, cpl_valid, error_valid, link_up}, 0);
    check("rst_cpl_fields", {cpl_status, cpl_data, cpl_tag}, 0);
    check("rst_err_fields", {error_type, error_header}, 0);
    check("rst_link_fields", {link_speed, link_width}, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      check("train_state", ltssm_state, (k >= 30) ? 3 : k / 10);
      check("train_link", {link_up, link_speed, link_width}, (k >= 30) ? {1'b1, 3'd3, 5'd16} : 9'd0);
    end
    check("train_ready", tlp_ready, 1);
    model_clear();
  endtask

  task automatic drive(input logic [2:0] typ, input logic [31:0] addr, input logic [31:0] data,
                       input logic [7:0] tag, input logic [9:0] len, input bit ie, input bit it, input bit im);
    tlp_valid = 1'b1; tlp_type = typ; tlp_address = addr; tlp_data = data; tlp_tag = tag; tlp_length = len;
    inject_ecrc_error = ie; inject_timeout = it; inject_malformed_tlp = im;
  endtask

  task automatic undrive();
    tlp_valid = 1'b0; inject_ecrc_error = 1'b0; inject_timeout = 1'b0; inject_malformed_tlp = 1'b0;
  endtask

  // One TLP from acceptance to quiescence, checked against the expected outcome.
  task automatic txn(input logic [2:0] typ, input logic [31:0] addr, input logic [31:0] data,
                     input logic [7:0] tag, input logic [9:0] len, input bit ie, input bit it,
                     input bit im, input int stall);
    bit          mal, ecrc, tmo, cpl_exp, cpl_seen, cpl_done, hs_next;
    logic [63:0] hdr;
    logic [3:0]  exp_t [2];
    int          exp_k [2];
    int          exp_n, eidx, stl;
    logic [2:0]  exp_st, c_st;
    logic [31:0] exp_dat, c_dat;
    logic [7:0]  c_tag;
    mal     = (typ > 3'd1) || (len != 10'd1) || (INJ && im);
    ecrc    = !mal && INJ && ie;
    tmo     = !mal && (typ == 3'd0) && INJ && it;
    cpl_exp = !mal && (typ == 3'd0) && !tmo;
    exp_st  = ecrc ? 3'b100 : 3'b000;
    exp_dat = ecrc ? 32'd0 : ref_mem[addr[5:2]];
    hdr     = {5'b0, typ, tag, 6'b0, len, addr};
    exp_n   = 0;
    if (mal) begin
      exp_t[0] = 4'd4; exp_k[0] = 1; exp_n = 1;
    end else begin
      if (ecrc) begin exp_t[exp_n] = 4'd3; exp_k[exp_n] = 1; exp_n++; end
      if (tmo) begin exp_t[exp_n] = 4'd2; exp_k[exp_n] = 64; exp_n++; end
    end
    wait_ready();
    drive(typ, addr, data, tag, len, ie, it, im);
    cpl_ready = (stall == 0);
    tick();
    undrive();
    ref_last_hdr = hdr;
    eidx = 0; stl = stall; cpl_seen = 0; cpl_done = 0; hs_next = 0;
    c_st = '0; c_dat = '0; c_tag = '0;
    for (int k = 0; k <= 90; k++) begin
      if (k > 0) tick();
      if (error_valid) begin
        if (eidx < exp_n) begin
          check("err_type", error_type, exp_t[eidx]);
          check("err_hdr", error_header, hdr);
          check("err_cycle", k, exp_k[eidx]);
        end else begin
          check("err_extra", eidx + 1, exp_n);
        end
        eidx++;
      end
      if (hs_next) begin
        check("cpl_release", cpl_valid, 0);
        hs_next = 0;
        cpl_done = 1;
      end else if (cpl_valid) begin
        if (!cpl_exp || cpl_done) begin
          check("cpl_unexpected", cpl_valid, 0);
          cpl_ready = 1'b1;
          break;
        end
        if (!cpl_seen) begin
          cpl_seen = 1;
          check("cpl_cycle", k, 4);
          check("cpl_tag", cpl_tag, tag);
          check("cpl_status", cpl_status, exp_st);
          check("cpl_data", cpl_data, exp_dat);
          c_st = cpl_status; c_dat = cpl_data; c_tag = cpl_tag;
        end else begin
          check("cpl_hold", {cpl_status, cpl_data, cpl_tag}, {c_st, c_dat, c_tag});
        end
        if (cpl_ready) hs_next = 1;
        else begin
          stl--;
          if (stl <= 0) begin cpl_ready = 1'b1; hs_next = 1; end
        end
      end
      if (eidx >= exp_n && (cpl_done || !cpl_exp) && k >= 6 && tlp_ready) break;
    end
    check("err_count", eidx, exp_n);
    check("cpl_done", cpl_done, cpl_exp);
    check("ready_after", tlp_ready, 1);
    cpl_ready = 1'b1;
    if (!mal && typ == 3'd1 && !ecrc) ref_mem[addr[5:2]] = data;
  endtask

  task automatic reset_mid(input logic [2:0] typ, input int rst_k);
    int ev = 0;
    wait_ready();
    drive(typ, 32'h0000_0008, 32'h0, 8'h33, 10'd1, 1'b0, 1'b0, 1'b0);
    tick();
    undrive();
    for (int k = 0; k < rst_k; k++) tick();
    rst_n = 1'b0;
    tick();
    tick();
    check("rstmid_quiet", {cpl_valid, error_valid, tlp_ready}, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (cpl_valid || error_valid) ev++;
    end
    check("rstmid_no_events", ev, 0);
    check("rstmid_relink", ltssm_state, 3);
    model_clear();
  endtask

`ifdef PCIE_LITE_ERR_INJ_EN
  task automatic lcrc_test();
    int ne = 0;
    inject_crc_error = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (error_valid) begin
        ne++;
        check("lcrc_type", error_type, 1);
        check("lcrc_hdr", error_header, ref_last_hdr);
        check("lcrc_cycle", k, 2);
      end
      if (k <= 20) begin
        check("rec_state", ltssm_state, 4);
        check("rec_link", {link_up, tlp_ready, link_speed, link_width}, 0);
      end else begin
        check("rec_back_l0", ltssm_state, 3);
      end
    end
    check("lcrc_once", ne, 1);
    inject_crc_error = 1'b0;
    tick();
  endtask

  task automatic lcrc_defer_test(input logic [31:0] addr, input logic [7:0] tag);
    bit          seen = 0;
    int          ne = 0;
    logic [63:0] hdr;
    hdr = {5'b0, 3'd0, tag, 6'b0, 10'd1, addr};
    wait_ready();
    cpl_ready = 1'b1;
    drive(3'd0, addr, 32'h0, tag, 10'd1, 1'b0, 1'b0, 1'b0);
    tick();
    undrive();
    ref_last_hdr = hdr;
    tick();
    inject_crc_error = 1'b1;
    for (int k = 2; k <= 40; k++) begin
      tick();
      if (error_valid) begin
        ne++;
        check("defer_lcrc_hdr", error_header, hdr);
      end
      if (cpl_valid && !seen) begin
        seen = 1;
        check("defer_cpl_in_l0", link_up, 1);
        check("defer_cpl_late", k >= 22, 1);
        check("defer_cpl_fields", {cpl_status, cpl_tag, cpl_data}, {3'b000, tag, ref_mem[addr[5:2]]});
      end
    end
    check("defer_err_count", ne, 1);
    check("defer_cpl_seen", seen, 1);
    check("defer_ready", tlp_ready, 1);
    inject_crc_error = 1'b0;
    tick();
  endtask
`else
  task automatic crc_ignored_test();
    int ne = 0;
    inject_crc_error = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (error_valid) ne++;
      check("crc_ignored_l0", ltssm_state, 3);
    end
    check("crc_ignored_err", ne, 0);
    inject_crc_error = 1'b0;
    tick();
  endtask
`endif

  logic [2:0]  r_typ;
  logic [9:0]  r_len;
  logic [31:0] r_addr;

  initial begin
    rst_n = 1'b0; cpl_ready = 1'b1; inject_crc_error = 1'b0;
    tlp_type = '0; tlp_address = '0; tlp_data = '0; tlp_tag = '0; tlp_length = '0;
    undrive();
    reset_and_train();
`ifdef PCIE_LITE_ERR_INJ_EN
    lcrc_test();
`endif
    txn(3'd1, 32'h0000_2000, 32'hDEAD_BEEF, 8'h00, 10'd1, 0, 0, 0, 0);
    txn(3'd0, 32'h0000_2000, 32'h0, 8'h01, 10'd1, 0, 0, 0, 5);
    txn(3'd7, 32'h0000_3000, 32'h0, 8'h06, 10'd1, 0, 0, 0, 0);
    txn(3'd0, 32'h0000_0004, 32'h0, 8'h07, 10'd2, 0, 0, 0, 0);
    txn(3'd1, 32'h0000_5000, 32'h1234_5678, 8'h08, 10'd1, 0, 0, 0, 0);
`ifdef PCIE_LITE_ERR_INJ_EN
    txn(3'd1, 32'h0000_5000, 32'hCAFE_BABE, 8'h02, 10'd1, 1, 0, 0, 0);
    txn(3'd0, 32'h0000_5000, 32'h0, 8'h03, 10'd1, 0, 0, 0, 0);
    txn(3'd0, 32'h0000_0100, 32'h0, 8'h04, 10'd1, 0, 1, 0, 0);
    txn(3'd0, 32'h0000_0104, 32'h0, 8'h05, 10'd1, 1, 0, 0, 2);
    txn(3'd0, 32'h0000_0108, 32'h0, 8'h09, 10'd1, 1, 1, 1, 0);
    lcrc_defer_test(32'h0000_2000, 8'h0A);
    lcrc_test();
`else
    txn(3'd1, 32'h0000_5000, 32'hCAFE_BABE, 8'h02, 10'd1, 1, 0, 1, 0);
    txn(3'd0, 32'h0000_5000, 32'h0, 8'h03, 10'd1, 0, 1, 0, 0);
    txn(3'd7, 32'h0000_3000, 32'h0, 8'h06, 10'd1, 1, 1, 1, 0);
    crc_ignored_test();
`endif
    for (int i = 0; i < 60; i++) begin
      r_typ  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(2, 7));
      r_len  = ($urandom_range(0, 9) < 9) ? 10'd1 : 10'($urandom);
      r_addr = $urandom;
      txn(r_typ, r_addr, $urandom, 8'($urandom), r_len,
          $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0,
          int'($urandom_range(0, 5)));
    end
    reset_mid(3'd0, 2);
    reset_mid(3'd7, 0);
    txn(3'd0, 32'h0000_2000, 32'h0, 8'h0B, 10'd1, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
